// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - oversampled UART receiver with per-entry-status RX FIFO and RTS flow control
module uart_rx_fifo #(
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int RTS_MARGIN = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          rx_tick,
    input  logic                          rx,
    input  logic [1:0]                    data_bit_num_i,
    input  logic                          parity_en_i,
    input  logic                          parity_type_i,
    input  logic                          stop_bit_num_i,
    input  logic                          rd_en_i,
    input  logic                          clr_overrun_i,
    output logic [7:0]                    rd_data_o,
    output logic [2:0]                    rd_status_o,
    output logic                          fifo_empty_o,
    output logic                          fifo_full_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          overrun_o,
    output logic                          rts_n,
    output logic                          rx_enable
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int M  = OVERSAMPLE / 2;

    localparam logic [CW-1:0] CNT_LO  = CW'(M - 1);
    localparam logic [CW-1:0] CNT_MID = CW'(M);
    localparam logic [CW-1:0] CNT_HI  = CW'(M + 1);
    localparam logic [CW-1:0] CNT_END = CW'(OVERSAMPLE - 1);

    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] RTS_LEVEL  = (AW + 1)'(FIFO_DEPTH - RTS_MARGIN);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t state, state_nxt;

    logic          rx_meta, rx_s;
    logic [CW-1:0] cnt;
    logic          samp_a, samp_b, bit_val;
    logic          tick_res, tick_end;
    logic [2:0]    bit_idx, last_idx;
    logic          stop_idx;
    logic [7:0]    data_sh;
    logic          par_bit, stop_err, first_stop;
    logic [1:0]    cfg_bits;
    logic          cfg_par_en, cfg_par_odd, cfg_stop2;
    logic          frame_done;
    logic          framing_now, first_stop_now, exp_par, parity_err, brk;
    logic [10:0]   entry;

    logic [10:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop, push, drop;
    logic [10:0]   head;

    // Two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign tick_res = rx_tick && (cnt == CNT_HI);
    assign tick_end = rx_tick && (cnt == CNT_END);
    assign bit_val  = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
    assign last_idx = 3'd4 + {1'b0, cfg_bits};

    // Next-state logic; a frame completes mid last stop bit so the next start edge is caught
    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        case (state)
            IDLE:      if (!rx_s) state_nxt = START;
            START: begin
                if (tick_res && bit_val)  state_nxt = IDLE;
                else if (tick_end)        state_nxt = DATA;
            end
            DATA:      if (tick_end && bit_idx == last_idx) state_nxt = cfg_par_en ? PARITY : STOP;
            PARITY:    if (tick_end) state_nxt = STOP;
            STOP: begin
                if (tick_res && stop_idx == cfg_stop2) begin
                    frame_done = 1'b1;
                    state_nxt  = rx_s ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: if (rx_s) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Bit timing, majority samples, frame accumulation and configuration latch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            samp_a      <= 1'b1;
            samp_b      <= 1'b1;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            data_sh     <= '0;
            par_bit     <= 1'b0;
            stop_err    <= 1'b0;
            first_stop  <= 1'b1;
            cfg_bits    <= '0;
            cfg_par_en  <= 1'b0;
            cfg_par_odd <= 1'b0;
            cfg_stop2   <= 1'b0;
        end else begin
            if (state == IDLE || state_nxt == IDLE || state_nxt == WAIT_HIGH)
                cnt <= '0;
            else if (rx_tick)
                cnt <= (cnt == CNT_END) ? '0 : cnt + 1'b1;

            if (rx_tick && cnt == CNT_LO)  samp_a <= rx_s;
            if (rx_tick && cnt == CNT_MID) samp_b <= rx_s;

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        cfg_bits    <= data_bit_num_i;
                        cfg_par_en  <= parity_en_i;
                        cfg_par_odd <= parity_type_i;
                        cfg_stop2   <= stop_bit_num_i;
                        data_sh     <= '0;
                        bit_idx     <= '0;
                        stop_idx    <= 1'b0;
                        par_bit     <= 1'b0;
                        stop_err    <= 1'b0;
                        first_stop  <= 1'b1;
                    end
                end
                DATA: begin
                    if (tick_res) data_sh[bit_idx] <= bit_val;
                    if (tick_end) bit_idx <= bit_idx + 1'b1;
                end
                PARITY: begin
                    if (tick_res) par_bit <= bit_val;
                end
                STOP: begin
                    if (tick_res) begin
                        if (!bit_val)  stop_err   <= 1'b1;
                        if (!stop_idx) first_stop <= bit_val;
                    end
                    if (tick_end) stop_idx <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Completed-frame status: a break is an all-zero frame up to and including the first stop bit
    assign framing_now    = stop_err | ~bit_val;
    assign first_stop_now = stop_idx ? first_stop : bit_val;
    assign exp_par        = cfg_par_odd ? ~(^data_sh) : ^data_sh;
    assign parity_err     = cfg_par_en && (par_bit != exp_par);
    assign brk            = (data_sh == 8'd0) && (!cfg_par_en || !par_bit) && !first_stop_now;
    assign entry          = {brk, framing_now, parity_err, data_sh};

    assign full = (count == FULL_LEVEL);
    assign pop  = rd_en_i && (count != '0);
    assign push = frame_done && (!full || pop);
    assign drop = frame_done && full && !pop;

    // FIFO storage; contents need no reset because the count gates visibility
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= entry;
    end

    // FIFO pointers, occupancy, sticky overrun and registered RTS
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun_o <= 1'b0;
            rts_n     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (drop)               overrun_o <= 1'b1;
            else if (clr_overrun_i) overrun_o <= 1'b0;
            rts_n <= (count >= RTS_LEVEL);
        end
    end

    assign head         = mem[rd_ptr];
    assign fifo_empty_o = (count == '0);
    assign fifo_full_o  = full;
    assign fifo_count_o = count;
    assign rd_data_o    = fifo_empty_o ? 8'd0 : head[7:0];
    assign rd_status_o  = fifo_empty_o ? 3'd0 : head[10:8];
    assign rx_enable    = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - randomized self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

    localparam int OS      = 16;
    localparam int DEPTH   = 8;
    localparam int MARGIN  = 2;
    localparam int TDIV    = 4;
    localparam int BIT_CYC = OS * TDIV;

    typedef struct {
        logic [7:0] d;
        logic [2:0] st;
    } ent_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx_tick;
    logic       rx;
    logic [1:0] data_bit_num_i;
    logic       parity_en_i;
    logic       parity_type_i;
    logic       stop_bit_num_i;
    logic       rd_en_user, rd_en_tick;
    logic       rd_en_i;
    logic       clr_overrun_i;
    logic [7:0] rd_data_o;
    logic [2:0] rd_status_o;
    logic       fifo_empty_o, fifo_full_o;
    logic [3:0] fifo_count_o;
    logic       overrun_o, rts_n, rx_enable;

    int   tests = 0;
    int   fails = 0;
    int   tick_no = 0;
    int   pop_target = -1;
    int   phase = 0;
    ent_t exp_q[$];
    logic model_ovr;

    assign rd_en_i = rd_en_user | rd_en_tick;

    always #5 clk = ~clk;

    uart_rx_fifo #(.OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH), .RTS_MARGIN(MARGIN)) dut (
        .clk(clk), .reset_n(reset_n), .rx_tick(rx_tick), .rx(rx),
        .data_bit_num_i(data_bit_num_i), .parity_en_i(parity_en_i),
        .parity_type_i(parity_type_i), .stop_bit_num_i(stop_bit_num_i),
        .rd_en_i(rd_en_i), .clr_overrun_i(clr_overrun_i),
        .rd_data_o(rd_data_o), .rd_status_o(rd_status_o),
        .fifo_empty_o(fifo_empty_o), .fifo_full_o(fifo_full_o),
        .fifo_count_o(fifo_count_o), .overrun_o(overrun_o),
        .rts_n(rts_n), .rx_enable(rx_enable)
    );

    // Oversample tick every TDIV clocks; optionally pops on a chosen tick
    initial begin
        rx_tick    = 1'b0;
        rd_en_tick = 1'b0;
        forever begin
            @(negedge clk);
            phase   = (phase + 1) % TDIV;
            rx_tick = (phase == 0);
            if (rx_tick) tick_no++;
            rd_en_tick = rx_tick && (tick_no == pop_target);
        end
    end

    // Sends one frame using the current config inputs; returns the entry the spec predicts
    task automatic send_frame(input logic [7:0] data, input bit flip_par, input bit bad_stop, output ent_t e);
        int         nbits;
        logic [7:0] d;
        logic       pbit;
        logic       pen;
        int         nstop;
        nbits = 5 + int'(data_bit_num_i);
        d     = data & 8'((1 << nbits) - 1);
        pen   = parity_en_i;
        nstop = stop_bit_num_i ? 2 : 1;
        pbit  = logic'($countones(d) % 2) ^ parity_type_i ^ flip_par;
        e.d   = d;
        e.st  = {(d == 8'd0) && (!pen || !pbit) && bad_stop, bad_stop, pen && flip_par};
        rx = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            rx = d[i];
            repeat (BIT_CYC) @(negedge clk);
        end
        if (pen) begin
            rx = pbit;
            repeat (BIT_CYC) @(negedge clk);
        end
        for (int s = 0; s < nstop; s++) begin
            rx = (s == 0 && bad_stop) ? 1'b0 : 1'b1;
            repeat (BIT_CYC) @(negedge clk);
        end
        rx = 1'b1;
        if (bad_stop) repeat (6) @(negedge clk);
    endtask

    task automatic model_push(input ent_t e, input bit pop_same);
        if (exp_q.size() < DEPTH) begin
            exp_q.push_back(e);
        end else if (pop_same) begin
            void'(exp_q.pop_front());
            exp_q.push_back(e);
        end else begin
            model_ovr = 1'b1;
        end
    endtask

    task automatic pop_head(output logic [7:0] d, output logic [2:0] st);
        d = rd_data_o;
        st = rd_status_o;
        rd_en_user = 1'b1;
        @(negedge clk);
        rd_en_user = 1'b0;
    endtask

    task automatic set_cfg(input logic [1:0] b, input logic pe, input logic po, input logic s2);
        data_bit_num_i = b;
        parity_en_i    = pe;
        parity_type_i  = po;
        stop_bit_num_i = s2;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (4) @(negedge clk);
        tests++; if ({rd_data_o, rd_status_o} !== 11'd0) begin fails++; $display("FAIL reset_head got=%h exp=0", {rd_data_o, rd_status_o}); end
        tests++; if ({fifo_empty_o, fifo_full_o, fifo_count_o} !== 6'b100000) begin fails++; $display("FAIL reset_fifo got=%b exp=100000", {fifo_empty_o, fifo_full_o, fifo_count_o}); end
        tests++; if ({overrun_o, rts_n, rx_enable} !== 3'b000) begin fails++; $display("FAIL reset_flags got=%b exp=000", {overrun_o, rts_n, rx_enable}); end
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        tests++; if ({fifo_empty_o, rx_enable} !== 2'b10) begin fails++; $display("FAIL reset_release got=%b exp=10", {fifo_empty_o, rx_enable}); end
    endtask

    task automatic test_basic;
        ent_t e; logic [7:0] d; logic [2:0] st;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b0, e);
        tests++; if (rd_data_o !== 8'hA5) begin fails++; $display("FAIL basic_data got=%h exp=a5", rd_data_o); end
        tests++; if (rd_status_o !== 3'b000) begin fails++; $display("FAIL basic_status got=%b exp=000", rd_status_o); end
        tests++; if (fifo_count_o !== 4'd1) begin fails++; $display("FAIL basic_count got=%0d exp=1", fifo_count_o); end
        pop_head(d, st);
        tests++; if ({fifo_empty_o, fifo_count_o} !== 5'b10000) begin fails++; $display("FAIL basic_pop got=%b exp=10000", {fifo_empty_o, fifo_count_o}); end
    endtask

    task automatic test_parity;
        ent_t e; logic [7:0] d; logic [2:0] st;
        set_cfg(2'b10, 1'b1, 1'b1, 1'b1);
        send_frame(8'h35, 1'b1, 1'b0, e);
        send_frame(8'h35, 1'b0, 1'b0, e);
        pop_head(d, st);
        tests++; if ({d, st} !== {8'h35, 3'b001}) begin fails++; $display("FAIL parity_bad got=%h/%b exp=35/001", d, st); end
        pop_head(d, st);
        tests++; if ({d, st} !== {8'h35, 3'b000}) begin fails++; $display("FAIL parity_good got=%h/%b exp=35/000", d, st); end
    endtask

    task automatic test_glitch;
        ent_t e; logic [7:0] d; logic [2:0] st;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (5 * TDIV) @(negedge clk);
        rx = 1'b1;
        repeat (30 * TDIV) @(negedge clk);
        tests++; if ({rx_enable, fifo_empty_o} !== 2'b01) begin fails++; $display("FAIL glitch_idle got=%b exp=01", {rx_enable, fifo_empty_o}); end
        send_frame(8'h3C, 1'b0, 1'b1, e);
        pop_head(d, st);
        tests++; if ({d, st} !== {8'h3C, 3'b010}) begin fails++; $display("FAIL framing got=%h/%b exp=3c/010", d, st); end
    endtask

    task automatic test_break;
        logic [7:0] d; logic [2:0] st;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (30 * BIT_CYC) @(negedge clk);
        tests++; if ({rx_enable, fifo_count_o} !== 5'b10001) begin fails++; $display("FAIL break_wait got=%b exp=10001", {rx_enable, fifo_count_o}); end
        rx = 1'b1;
        repeat (10) @(negedge clk);
        tests++; if (rx_enable !== 1'b0) begin fails++; $display("FAIL break_idle got=%b exp=0", rx_enable); end
        pop_head(d, st);
        tests++; if ({d, st} !== {8'h00, 3'b110}) begin fails++; $display("FAIL break_entry got=%h/%b exp=00/110", d, st); end
        tests++; if (fifo_empty_o !== 1'b1) begin fails++; $display("FAIL break_single got=%b exp=1", fifo_empty_o); end
    endtask

    task automatic test_back_to_back;
        ent_t e, x; logic [7:0] d; logic [2:0] st; logic [7:0] dat;
        for (int b = 0; b < 3; b++) begin
            for (int f = 0; f < 4; f++) begin
                set_cfg(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                dat = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
                send_frame(dat, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, e);
                model_push(e, 1'b0);
            end
            tests++; if (fifo_count_o !== 4'(exp_q.size())) begin fails++; $display("FAIL b2b_count got=%0d exp=%0d", fifo_count_o, exp_q.size()); end
            while (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                pop_head(d, st);
                tests++; if ({d, st} !== {x.d, x.st}) begin fails++; $display("FAIL b2b_entry got=%h/%b exp=%h/%b", d, st, x.d, x.st); end
            end
        end
    endtask

    task automatic test_overrun;
        ent_t e, x; logic [7:0] d; logic [2:0] st; bit seen;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        model_ovr = 1'b0;
        for (int i = 1; i <= DEPTH + 1; i++) begin
            send_frame(8'($urandom), 1'b0, 1'b0, e);
            model_push(e, 1'b0);
            tests++; if (fifo_count_o !== 4'(exp_q.size())) begin fails++; $display("FAIL ovr_count got=%0d exp=%0d", fifo_count_o, exp_q.size()); end
            tests++; if (rts_n !== (exp_q.size() >= DEPTH - MARGIN)) begin fails++; $display("FAIL ovr_rts got=%b at frame %0d", rts_n, i); end
            tests++; if (fifo_full_o !== (exp_q.size() == DEPTH)) begin fails++; $display("FAIL ovr_full got=%b at frame %0d", fifo_full_o, i); end
            tests++; if (overrun_o !== model_ovr) begin fails++; $display("FAIL ovr_flag got=%b exp=%b", overrun_o, model_ovr); end
        end
        tests++; if (rd_data_o !== exp_q[0].d) begin fails++; $display("FAIL ovr_head got=%h exp=%h", rd_data_o, exp_q[0].d); end
        clr_overrun_i = 1'b1;
        @(negedge clk);
        clr_overrun_i = 1'b0;
        tests++; if (overrun_o !== 1'b0) begin fails++; $display("FAIL ovr_clear got=%b exp=0", overrun_o); end
        seen = 1'b0;
        fork
            send_frame(8'($urandom), 1'b0, 1'b0, e);
            begin
                for (int c = 0; c < 40 && !seen; c++) begin
                    @(posedge clk); #1;
                    if (rx_enable) seen = 1'b1;
                end
                if (seen) pop_target = tick_no + OS * 9 + OS / 2 + 2;
            end
        join
        pop_target = -1;
        tests++; if (!seen) begin fails++; $display("FAIL ovr_start_detect got=0 exp=1"); end
        model_push(e, 1'b1);
        tests++; if ({fifo_count_o, overrun_o} !== {4'd8, 1'b0}) begin fails++; $display("FAIL ovr_pushpop got=%0d/%b exp=8/0", fifo_count_o, overrun_o); end
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            pop_head(d, st);
            tests++; if ({d, st} !== {x.d, x.st}) begin fails++; $display("FAIL ovr_entry got=%h/%b exp=%h/%b", d, st, x.d, x.st); end
        end
        @(negedge clk);
        tests++; if ({fifo_empty_o, rts_n} !== 2'b10) begin fails++; $display("FAIL ovr_drain got=%b exp=10", {fifo_empty_o, rts_n}); end
    endtask

    task automatic test_reset_mid;
        ent_t e; logic [7:0] d; logic [2:0] st;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h77, 1'b0, 1'b0, e);
        rx = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BIT_CYC) @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if ({rd_data_o, rd_status_o, fifo_empty_o, fifo_full_o, fifo_count_o} !== {11'd0, 6'b100000}) begin fails++; $display("FAIL rstmid_fifo got=%h exp=20", {rd_data_o, rd_status_o, fifo_empty_o, fifo_full_o, fifo_count_o}); end
        tests++; if ({overrun_o, rts_n, rx_enable} !== 3'b000) begin fails++; $display("FAIL rstmid_flags got=%b exp=000", {overrun_o, rts_n, rx_enable}); end
        reset_n = 1'b1;
        repeat (5 * BIT_CYC) @(negedge clk);
        tests++; if ({rx_enable, fifo_empty_o} !== 2'b01) begin fails++; $display("FAIL rstmid_idle got=%b exp=01", {rx_enable, fifo_empty_o}); end
        send_frame(8'h5A, 1'b0, 1'b0, e);
        tests++; if (fifo_count_o !== 4'd1) begin fails++; $display("FAIL rstmid_count got=%0d exp=1", fifo_count_o); end
        pop_head(d, st);
        tests++; if ({d, st} !== {8'h5A, 3'b000}) begin fails++; $display("FAIL rstmid_entry got=%h/%b exp=5a/000", d, st); end
    endtask

    initial begin
        reset_n       = 1'b0;
        rx            = 1'b1;
        rd_en_user    = 1'b0;
        clr_overrun_i = 1'b0;
        model_ovr     = 1'b0;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        test_reset;
        test_basic;
        test_parity;
        test_glitch;
        test_break;
        test_back_to_back;
        test_overrun;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
